// File: rtl/bpu_lvl_2.sv
// ---------------------------------------------------------------------------
// bpu_lvl_2 -- two-level branch direction predictor (bimodal or gshare)
//
// A table of 2^JUMP_AREA saturating counters, CW = $clog2(STEP_NUM) bits
// each. A prediction request looks up one counter and returns the direction
// one cycle later. A resolved-branch update trains one counter, shifts the
// outcome into the global history register and counts mispredictions.
// After reset the table is swept to "weakly not-taken" one entry per cycle.
// Until that sweep finishes, ready_o is low and all requests are ignored.
//
// Ports
//   clk_i            single clock, rising edge
//   arst_i           asynchronous reset, active low
//   pred_valid_i     prediction request
//   pred_pc_i        branch PC of the request
//   pred_valid_o     prediction result valid (one cycle after the request)
//   pred_taken_o     predicted direction (held when no result)
//   pred_idx_o       table index used (held when no result)
//   upd_valid_i      resolved-branch update
//   upd_idx_i        index to train (the pred_idx_o returned earlier)
//   upd_taken_i      actual outcome
//   upd_mispredict_i resolved branch was mispredicted
//   ready_o          table initialised, requests accepted
//   mispred_cnt_o    saturating misprediction count
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | table sweep, one entry per cycle; requests and updates ignored
// ST_RUN  | normal operation; prediction and update in parallel
// ---------------------------------------------------------------------------
module bpu_lvl_2 #(
    parameter int STEP_NUM   = 4,
    parameter int JUMP_AREA  = 12,
    parameter int HIST_WIDTH = 8,
    parameter int MODE       = 1,
    parameter int PC_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 pred_valid_i,
    input  logic [PC_WIDTH-1:0]  pred_pc_i,
    output logic                 pred_valid_o,
    output logic                 pred_taken_o,
    output logic [JUMP_AREA-1:0] pred_idx_o,
    input  logic                 upd_valid_i,
    input  logic [JUMP_AREA-1:0] upd_idx_i,
    input  logic                 upd_taken_i,
    input  logic                 upd_mispredict_i,
    output logic                 ready_o,
    output logic [15:0]          mispred_cnt_o
);

    localparam int CW    = $clog2(STEP_NUM);
    localparam int DEPTH = 1 << JUMP_AREA;

    localparam logic [CW-1:0]        CNT_MAX  = CW'(STEP_NUM - 1);
    localparam logic [CW-1:0]        CNT_INIT = CW'(STEP_NUM / 2 - 1);
    localparam logic [CW-1:0]        CNT_THR  = CW'(STEP_NUM / 2);
    localparam logic [JUMP_AREA-1:0] IDX_LAST = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [JUMP_AREA-1:0]   init_idx_q, init_idx_d;
    logic [HIST_WIDTH-1:0]  ghr_q, ghr_d;
    logic                   pred_valid_q, pred_valid_d;
    logic                   pred_taken_q, pred_taken_d;
    logic [JUMP_AREA-1:0]   pred_idx_q, pred_idx_d;
    logic                   ready_q, ready_d;
    logic [15:0]            mispred_q, mispred_d;

    // Counter table; no reset, the INIT sweep defines every entry before use.
    logic [CW-1:0]          table_q [DEPTH];

    logic [JUMP_AREA-1:0]   pc_idx;
    logic [JUMP_AREA-1:0]   lookup_idx;
    logic                   pred_acc;
    logic                   upd_acc;
    logic [CW-1:0]          upd_cnt;
    logic [CW-1:0]          upd_cnt_next;
    logic                   tbl_we;
    logic [JUMP_AREA-1:0]   tbl_waddr;
    logic [CW-1:0]          tbl_wdata;

    generate
        if (PC_WIDTH > JUMP_AREA + 2) begin : g_pc_hi
            logic unused_pc_bits;
            assign unused_pc_bits = ^{pred_pc_i[PC_WIDTH-1:JUMP_AREA+2], pred_pc_i[1:0]};
        end else begin : g_pc_lo
            logic unused_pc_bits;
            assign unused_pc_bits = ^pred_pc_i[1:0];
        end
    endgenerate

    always_comb begin
        pc_idx = pred_pc_i[JUMP_AREA+1:2];
        if (MODE == 1) begin
            lookup_idx = pc_idx ^ JUMP_AREA'(ghr_q);
        end else begin
            lookup_idx = pc_idx;
        end

        pred_acc = (state_q == ST_RUN) && pred_valid_i;
        upd_acc  = (state_q == ST_RUN) && upd_valid_i;

        upd_cnt      = table_q[upd_idx_i];
        upd_cnt_next = upd_cnt;
        if (upd_taken_i) begin
            if (upd_cnt != CNT_MAX) begin
                upd_cnt_next = upd_cnt + CW'(1);
            end
        end else begin
            if (upd_cnt != '0) begin
                upd_cnt_next = upd_cnt - CW'(1);
            end
        end

        // Only one writer per cycle: the sweep in INIT, training in RUN.
        if (state_q == ST_INIT) begin
            tbl_we    = 1'b1;
            tbl_waddr = init_idx_q;
            tbl_wdata = CNT_INIT;
        end else begin
            tbl_we    = upd_acc;
            tbl_waddr = upd_idx_i;
            tbl_wdata = upd_cnt_next;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        ghr_d        = ghr_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;
        mispred_d    = mispred_q;

        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + JUMP_AREA'(1);
                if (init_idx_q == IDX_LAST) begin
                    state_d    = ST_RUN;
                    init_idx_d = '0;
                end
            end
            ST_RUN: begin
                // The read sees the table before this cycle's update lands,
                // so a same-index predict returns the pre-update counter.
                if (pred_acc) begin
                    pred_valid_d = 1'b1;
                    pred_taken_d = (table_q[lookup_idx] >= CNT_THR);
                    pred_idx_d   = lookup_idx;
                end
                if (upd_acc) begin
                    ghr_d = HIST_WIDTH'({ghr_q, upd_taken_i});
                    if (upd_mispredict_i && (mispred_q != 16'hFFFF)) begin
                        mispred_d = mispred_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q      <= ST_INIT;
            init_idx_q   <= '0;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
            ready_q      <= 1'b0;
            mispred_q    <= '0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
            ready_q      <= ready_d;
            mispred_q    <= mispred_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tbl_we) begin
            table_q[tbl_waddr] <= tbl_wdata;
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_idx_o    = pred_idx_q;
    assign ready_o       = ready_q;
    assign mispred_cnt_o = mispred_q;

endmodule

// File: tb/tb_bpu_lvl_2.sv
// ---------------------------------------------------------------------------
// tb_bpu_lvl_2 -- directed bench for bpu_lvl_2 (STEP_NUM=4, JUMP_AREA=4,
// HIST_WIDTH=4). dut0 is bimodal, dut1 is gshare; both see the same inputs.
// ---------------------------------------------------------------------------
module tb_bpu_lvl_2;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        pred_valid_i;
    logic [31:0] pred_pc_i;
    logic        upd_valid_i;
    logic [3:0]  upd_idx_i;
    logic        upd_taken_i;
    logic        upd_mispredict_i;

    logic        pv0, tk0, rdy0, pv1, tk1, rdy1;
    logic [3:0]  idx0, idx1;
    logic [15:0] mis0, mis1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk_i = ~clk_i;

    bpu_lvl_2 #(.STEP_NUM(4), .JUMP_AREA(4), .HIST_WIDTH(4), .MODE(0), .PC_WIDTH(32)) dut0 (
        .clk_i(clk_i), .arst_i(arst_i),
        .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
        .pred_valid_o(pv0), .pred_taken_o(tk0), .pred_idx_o(idx0),
        .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i),
        .upd_taken_i(upd_taken_i), .upd_mispredict_i(upd_mispredict_i),
        .ready_o(rdy0), .mispred_cnt_o(mis0)
    );

    bpu_lvl_2 #(.STEP_NUM(4), .JUMP_AREA(4), .HIST_WIDTH(4), .MODE(1), .PC_WIDTH(32)) dut1 (
        .clk_i(clk_i), .arst_i(arst_i),
        .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
        .pred_valid_o(pv1), .pred_taken_o(tk1), .pred_idx_o(idx1),
        .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i),
        .upd_taken_i(upd_taken_i), .upd_mispredict_i(upd_mispredict_i),
        .ready_o(rdy1), .mispred_cnt_o(mis1)
    );

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        uv;
        logic [3:0]  ui;
        logic        ut;
        logic        um;
        logic        e_pv;
        logic        e_tk;
        logic [3:0]  e_idx;
        logic [15:0] e_mis;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        pred_valid_i     = 1'b0;
        pred_pc_i        = 32'h0;
        upd_valid_i      = 1'b0;
        upd_idx_i        = 4'h0;
        upd_taken_i      = 1'b0;
        upd_mispredict_i = 1'b0;
    endtask

    // One clock cycle with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic uv,
                       input logic [3:0] ui, input logic ut, input logic um);
        pred_valid_i     = pv;
        pred_pc_i        = pc;
        upd_valid_i      = uv;
        upd_idx_i        = ui;
        upd_taken_i      = ut;
        upd_mispredict_i = um;
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    // Counts the INIT sweep: ready must stay low for 15 edges and rise on the 16th.
    task automatic init_sweep(input string tag);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_i);
            #1;
            chk({tag, "_ready0"}, rdy0, (k == 16));
            chk({tag, "_ready1"}, rdy1, (k == 16));
            chk({tag, "_pvalid"}, pv0, 1'b0);
            chk({tag, "_mis"}, mis0, 16'h0);
        end
    endtask

    initial begin
        // Rows are consecutive cycles on dut0 (bimodal); entry 7 = 3, rest = 1 on entry.
        vec[0]  = '{1'b0, 32'h0,        1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  16'd0};
        vec[1]  = '{1'b1, 32'h0000_000C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  16'd0};
        vec[2]  = '{1'b0, 32'h0,        1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  16'd0};
        vec[3]  = '{1'b0, 32'h0,        1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  16'd0};
        vec[4]  = '{1'b0, 32'h0,        1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  16'd0};
        vec[5]  = '{1'b0, 32'h0,        1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  16'd0};
        vec[6]  = '{1'b0, 32'h0,        1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  16'd0};
        vec[7]  = '{1'b0, 32'h0,        1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  16'd0};
        vec[8]  = '{1'b1, 32'h0000_000C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  16'd0};
        vec[9]  = '{1'b1, 32'h0000_0014, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5,  16'd0};
        vec[10] = '{1'b1, 32'h0000_0014, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  16'd0};
        vec[11] = '{1'b0, 32'h0,        1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  16'd0};
        vec[12] = '{1'b0, 32'h0,        1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  16'd0};
        vec[13] = '{1'b0, 32'h0,        1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b1, 4'd5,  16'd0};
        vec[14] = '{1'b1, 32'h0000_0024, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9,  16'd0};
        vec[15] = '{1'b0, 32'h0,        1'b1, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9,  16'd1};
        vec[16] = '{1'b0, 32'h0,        1'b1, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9,  16'd2};
        vec[17] = '{1'b0, 32'h0,        1'b1, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  16'd3};
        vec[18] = '{1'b0, 32'h0,        1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9,  16'd3};
        vec[19] = '{1'b1, 32'hFFFF_FFCB, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2,  16'd3};
        vec[20] = '{1'b1, 32'h0000_0028, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd10, 16'd3};

        // Reset held with every request line active.
        arst_i           = 1'b0;
        pred_valid_i     = 1'b1;
        pred_pc_i        = 32'h0000_0010;
        upd_valid_i      = 1'b1;
        upd_idx_i        = 4'd4;
        upd_taken_i      = 1'b1;
        upd_mispredict_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", rdy0, 1'b0);
        chk("rst_pvalid", pv0, 1'b0);
        chk("rst_taken", tk0, 1'b0);
        chk("rst_idx", idx0, 4'd0);
        chk("rst_mis", mis0, 16'd0);
        chk("rst_pvalid_gs", pv1, 1'b0);

        // Release with requests still active: INIT must ignore them.
        arst_i = 1'b1;
        init_sweep("init");
        idle_inputs();

        // First prediction after INIT: weakly not-taken, idx 4 (GHR still 0).
        cyc(1'b1, 32'h0000_0010, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("first_pv", pv0, 1'b1);
        chk("first_tk", tk0, 1'b0);
        chk("first_idx", idx0, 4'd4);
        chk("first_pv_gs", pv1, 1'b1);
        chk("first_tk_gs", tk1, 1'b0);
        chk("first_idx_gs", idx1, 4'd4);
        cyc(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("idle_pv", pv0, 1'b0);
        chk("idle_idx_hold", idx0, 4'd4);

        // Gshare: two taken updates to idx 7 -> GHR = 0011, entry 7 = 3.
        cyc(1'b0, 32'h0, 1'b1, 4'd7, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 4'd7, 1'b1, 1'b0);
        cyc(1'b1, 32'h0000_0010, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("gs_idx7", idx1, 4'd7);
        chk("gs_tk7", tk1, 1'b1);
        chk("bm_idx4", idx0, 4'd4);
        chk("bm_tk4", tk0, 1'b0);
        cyc(1'b1, 32'h0000_000C, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("gs_idx0", idx1, 4'd0);
        chk("gs_tk0", tk1, 1'b0);
        chk("gs_pv", pv1, 1'b1);
        chk("bm_idx3", idx0, 4'd3);
        chk("bm_tk3", tk0, 1'b0);

        // Table-driven bimodal sequence.
        for (int i = 0; i < NVEC; i++) begin
            cyc(vec[i].pv, vec[i].pc, vec[i].uv, vec[i].ui, vec[i].ut, vec[i].um);
            chk($sformatf("vec%0d_pv", i), pv0, vec[i].e_pv);
            chk($sformatf("vec%0d_tk", i), tk0, vec[i].e_tk);
            chk($sformatf("vec%0d_idx", i), idx0, vec[i].e_idx);
            chk($sformatf("vec%0d_mis", i), mis0, vec[i].e_mis);
        end

        // Asynchronous reset mid-RUN takes effect without a clock edge.
        #1;
        arst_i = 1'b0;
        #2;
        chk("arst_run_mis", mis0, 16'd0);
        chk("arst_run_ready", rdy0, 1'b0);
        chk("arst_run_pv", pv0, 1'b0);
        chk("arst_run_idx", idx0, 4'd0);
        @(posedge clk_i);
        #1;
        arst_i = 1'b1;

        // Reset again mid-INIT; the sweep must restart from zero.
        repeat (5) @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        #2;
        chk("arst_init_ready", rdy0, 1'b0);
        @(posedge clk_i);
        #1;
        arst_i = 1'b1;
        init_sweep("reinit");

        // Trained entries and history do not survive reset.
        cyc(1'b1, 32'h0000_000C, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("post_rst_tk", tk0, 1'b0);
        chk("post_rst_idx", idx0, 4'd3);
        chk("post_rst_idx_gs", idx1, 4'd3);
        cyc(1'b1, 32'h0000_001C, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("post_rst_tk7", tk0, 1'b0);
        chk("post_rst_tk7_gs", tk1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/bpu_lvl_2.md
BPU_LVL_2 -- requirements
Module: bpu_lvl_2

Interface
REQ-001 SHALL have parameter STEP_NUM, default 4: counter states per entry; power of two, >= 2.
REQ-002 SHALL have parameter JUMP_AREA, default 12: table index width; table depth 2^JUMP_AREA.
REQ-003 SHALL have parameter HIST_WIDTH, default 8: global history register (GHR) width; 1 <= HIST_WIDTH <= JUMP_AREA.
REQ-004 SHALL have parameter MODE, default 1: 0 = bimodal, 1 = gshare.
REQ-005 SHALL have parameter PC_WIDTH, default 32: PC width; PC_WIDTH >= JUMP_AREA+2.
REQ-006 SHALL have port clk_i, input, 1: the single clock; all state on rising edge.
REQ-007 SHALL have port arst_i, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port pred_valid_i, input, 1: prediction request.
REQ-009 SHALL have port pred_pc_i, input, PC_WIDTH: branch PC.
REQ-010 SHALL have port pred_valid_o, output, 1: prediction result valid.
REQ-011 SHALL have port pred_taken_o, output, 1: predicted direction.
REQ-012 SHALL have port pred_idx_o, output, JUMP_AREA: table index used; returned by the caller on update.
REQ-013 SHALL have port upd_valid_i, input, 1: resolved-branch update.
REQ-014 SHALL have port upd_idx_i, input, JUMP_AREA: index to train.
REQ-015 SHALL have port upd_taken_i, input, 1: actual outcome.
REQ-016 SHALL have port upd_mispredict_i, input, 1: the resolved branch was mispredicted.
REQ-017 SHALL have port ready_o, output, 1: table initialised; requests accepted.
REQ-018 SHALL have port mispred_cnt_o, output, 16: saturating misprediction count.

Function
REQ-019 Counter width CW = $clog2(STEP_NUM); one CW-bit counter per entry.
REQ-020 Index: pc_idx = pred_pc_i[JUMP_AREA+1:2]; MODE 0 idx = pc_idx; MODE 1 idx = pc_idx XOR zero-extended GHR.
REQ-021 Index SHALL use the GHR value current in the request cycle.
REQ-022 Prediction latency 1 cycle: request accepted in cycle N gives pred_valid_o=1 with pred_taken_o and pred_idx_o in cycle N+1.
REQ-023 pred_valid_o SHALL be 0 in cycles with no accepted request; pred_taken_o and pred_idx_o hold their last values.
REQ-024 pred_taken_o = 1 iff the entry's counter >= STEP_NUM/2.
REQ-025 Update with upd_taken_i=1: entry saturating-increments, max STEP_NUM-1.
REQ-026 Update with upd_taken_i=0: entry saturating-decrements, min 0.
REQ-027 On each accepted update, GHR <= {GHR[HIST_WIDTH-2:0], upd_taken_i}. History is non-speculative.
REQ-028 Prediction and update to the same index in the same cycle: prediction SHALL return the pre-update counter; the update is still applied.
REQ-029 Each accepted update with upd_mispredict_i=1 increments mispred_cnt_o, saturating at 16'hFFFF.
REQ-030 FSM states INIT and RUN.
 - INIT writes STEP_NUM/2-1 (weakly not-taken) to one entry per cycle, index 0 up to 2^JUMP_AREA-1.
 - After the last entry is written: INIT -> RUN.
REQ-031 ready_o = 1 only in RUN.
REQ-032 In INIT, pred_valid_i and upd_valid_i SHALL be ignored: no output, no training, no GHR or counter change.
REQ-033 RUN SHALL accept a prediction and an update in the same cycle without stall.

Reset
REQ-034 While arst_i=0, state = INIT with init index 0, and:
 - GHR = 0
 - pred_valid_o = 0, pred_taken_o = 0, pred_idx_o = 0
 - ready_o = 0
 - mispred_cnt_o = 0
REQ-035 arst_i assertion SHALL take effect immediately from any state, including mid-INIT and mid-RUN.
REQ-036 After arst_i rises, INIT restarts and runs a full 2^JUMP_AREA-cycle sweep.
REQ-037 No table contents SHALL survive reset as observable state.

Verification
All scenarios use STEP_NUM=4, JUMP_AREA=4, HIST_WIDTH=4, PC_WIDTH=32.
REQ-038 Release arst_i -> ready_o=0 for 16 cycles, then 1. Predict pc 0x0000_0010 -> next cycle pred_valid_o=1, pred_taken_o=0, pred_idx_o=4.
REQ-039 MODE 0: one update idx 3 taken -> predict pc 0x0C gives pred_taken_o=1. Then 5 more taken updates and 1 not-taken -> predict pc 0x0C gives pred_taken_o=1 (counter 3 then 2).
REQ-040 MODE 1: two taken updates to idx 7 (GHR=4'b0011) -> predict pc 0x0C gives pred_idx_o=0, pred_taken_o=0.
REQ-041 Same cycle: update idx 5 taken and predict pc 0x14 (MODE 0, counter=1) -> pred_taken_o=0. A repeat predict next cycle -> pred_taken_o=1.
REQ-042 Three updates with upd_mispredict_i=1 and one with 0 -> mispred_cnt_o=3. Pull arst_i low mid-RUN -> mispred_cnt_o=0 and ready_o=0 immediately, ready_o high 16 cycles after release.
REQ-043 pred_valid_i and upd_valid_i held high during INIT -> pred_valid_o stays 0. After INIT, first predict at any index -> pred_taken_o=0.
